exchange_scheduler: RTL and testbench
=====================================

// Module: exchange_scheduler
// PURPOSE
//  Top-level sequencer for the replica array. Runs all metropolis replicas for a programmed number of steps
//  (one sweep), waits for the replica pipeline to drain, and then evaluates replica-exchange acceptance for
//  adjacent pairs one pair per cycle. It then issues one cycle of PREV/FOLW/NOP exchange commands to every replica.
//  Pair parity alternates even/odd on successive rounds; the block repeats for a programmed number of rounds.
// PARAMETERS
//  NREP      32  number of replicas (>=2); replica i runs at beta=(i+1)*dbeta (dbeta from replica_pkg)
//  PIPE_LAT  4   cycles metropolis_run stays low after a sweep before total energies are stable
// PORTS
//  clk          in   1              clock, all state on rising edge
//  reset        in   1              asynchronous, active-low reset
//  start        in   1              begin a run; sampled only in IDLE
//  sweep_len    in   16             metropolis steps per sweep; sampled at start; 0 treated as 1
//  n_round      in   16             exchange rounds per run; sampled at start
//  energy       in   NREP x total_data_t   out_data of each replica (total distance)
//  r_exchange   in   32             uniform random word, fresh each cycle; [22:0] used
//  metropolis_run out 1             enables metropolis step in all replicas
//  command      out  NREP x exchange_command_t   per-replica exchange command
//  busy         out  1              high from the cycle after start until DONE is left
//  done         out  1              one-cycle pulse at end of run
//  round_cnt    out  16             rounds completed in current/last run
//  accept_cnt   out  16             accepted swaps in current/last run, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; metropolis_run=0; command all NOP; busy=0; done=0.
//   Reset also clears parity, pair index, acc vector, round_cnt and accept_cnt. A reset mid-run aborts at once.
//  FSM: IDLE -> SWEEP -> DRAIN -> EXCH -> APPLY -> (SWEEP | DONE) -> IDLE.
//  IDLE: start=1 -> latch sweep_len/n_round, clear round_cnt/accept_cnt/parity.
//   The next state is SWEEP, or DONE if n_round==0.
//  SWEEP: metropolis_run=1 for exactly max(sweep_len,1) consecutive cycles, then DRAIN.
//  DRAIN: metropolis_run=0 for PIPE_LAT cycles, then EXCH with pair index p=parity.
//  EXCH: one cycle per pair (p,p+1) for p=parity, parity+2, ... while p+1<NREP.
//   de = $signed(energy[p+1]) - $signed(energy[p]), 33-bit signed.
//   x = (de*dbeta)>>>3, truncated to 32 bits, fed to the codebase exp unit.
//   accept = (de>=0) || (y > r_exchange[22:0]); latched into acc[p].
//   If no pair exists (NREP==2, parity=1), EXCH is skipped and APPLY issues all NOP.
//  APPLY (1 cycle, registered outputs):
//   acc[p]=1 -> command[p]=FOLW, command[p+1]=PREV.
//   Replicas not in an accepted pair get NOP.
//   command returns to all NOP on the following cycle.
//   accept_cnt += popcount(acc), saturating. round_cnt++; parity toggles; acc cleared.
//   Next state is DONE if round_cnt+1==n_round, else SWEEP.
//  DONE: done=1 for one cycle, busy=0 from the following cycle, -> IDLE.
//  start while busy: ignored. energy must stay stable during EXCH; it does, because metropolis_run=0.
//  A run takes n_round*(sweep_len'+PIPE_LAT+npairs+1)+1 cycles after start.
// TESTING
//  1. NREP=4, sweep_len=3, n_round=1, energy={40,30,20,10} (idx0..3):
//     -> run=1 for 3 cycles, pairs (0,1),(2,3), de<0.
//     r=23'h7FFFFF -> all NOP, accept_cnt=0, done pulse.
//  2. energy={10,20,30,40}, n_round=2:
//     -> round0: cmd={FOLW,PREV,FOLW,PREV}.
//     -> round1 (odd): cmd[1]=FOLW, cmd[2]=PREV, cmd[0]=cmd[3]=NOP; accept_cnt=3, round_cnt=2.
//  3. de<0 with r_exchange=0 -> accepted when y>0.
//     Same de with r_exchange[22:0]=23'h7FFFFF -> rejected.
//  4. sweep_len=0, n_round=0 -> done 1 cycle after start, no run pulse.
//     sweep_len=0, n_round=1 -> exactly 1 run cycle.
//  5. start held high during SWEEP ignored.
//     reset=0 mid-EXCH -> outputs return to reset values asynchronously; a new start runs cleanly.
//  6. NREP=2, n_round=2 -> round1 issues all NOP with no EXCH cycle.
//     Total cycle count matches the formula above.

Source files
------------

// File: rtl/exchange_scheduler.sv
// exchange_scheduler
//   Sequencer for the replica array. Each round runs every metropolis replica for
//   max(sweep_len,1) steps, lets the replica pipeline drain, evaluates
//   replica-exchange acceptance for adjacent pairs (one pair per cycle, parity
//   alternating between rounds), then issues one cycle of exchange commands.
//
// Ports
//   i_clk             clock, all state on the rising edge
//   i_reset           asynchronous active-low reset
//   i_start           begin a run, sampled only in IDLE
//   i_sweep_len       metropolis steps per sweep, latched at start (0 acts as 1)
//   i_n_round         exchange rounds per run, latched at start
//   i_energy          NREP packed 32-bit signed total energies, replica i at [32*i +: 32]
//   i_r_exchange      fresh uniform random word each cycle, bits [22:0] used
//   o_metropolis_run  metropolis step enable for all replicas
//   o_command         NREP packed 2-bit commands (NOP=0, PREV=1, FOLW=2)
//   o_busy            high from the cycle after start until DONE is left
//   o_done            one-cycle pulse at end of run
//   o_round_cnt       rounds completed in the current/last run
//   o_accept_cnt      accepted swaps in the current/last run, saturating
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_SWEEP | metropolis_run high, down-counting the sweep length
//   S_DRAIN | metropolis_run low, down-counting the pipeline latency
//   S_EXCH  | one adjacent pair (p,p+1) evaluated per cycle
//   S_APPLY | registered exchange commands driven for one cycle
//   S_DONE  | done pulse, back to idle

module exchange_scheduler #(
    parameter int NREP     = 32,
    parameter int PIPE_LAT = 4,    // >= 1
    parameter int DBETA    = 1     // beta step between neighbouring replicas
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [15:0]         i_sweep_len,
    input  logic [15:0]         i_n_round,
    input  logic [NREP*32-1:0]  i_energy,
    input  logic [31:0]         i_r_exchange,
    output logic                o_metropolis_run,
    output logic [2*NREP-1:0]   o_command,
    output logic                o_busy,
    output logic                o_done,
    output logic [15:0]         o_round_cnt,
    output logic [15:0]         o_accept_cnt
);

    localparam int          PW     = $clog2(NREP) + 1;
    localparam logic [31:0] NREP_U = 32'(NREP);
    localparam logic [1:0]  CMD_PREV = 2'd1;
    localparam logic [1:0]  CMD_FOLW = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_SWEEP, S_DRAIN, S_EXCH, S_APPLY, S_DONE
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [15:0]         r_timer,      w_timer_nxt;
    logic [15:0]         r_sweep_len,  w_sweep_len_nxt;
    logic [15:0]         r_n_round,    w_n_round_nxt;
    logic                r_parity,     w_parity_nxt;
    logic [PW-1:0]       r_pair,       w_pair_nxt;
    logic [NREP-1:0]     r_acc,        w_acc_nxt;
    logic [2*NREP-1:0]   r_command,    w_command_nxt;
    logic [15:0]         r_round_cnt,  w_round_cnt_nxt;
    logic [15:0]         r_accept_cnt, w_accept_cnt_nxt;

    // ---------------------------------------------------------------
    // Acceptance datapath for the pair currently addressed by r_pair
    // ---------------------------------------------------------------
    logic [31:0]         w_e_lo, w_e_hi;
    logic [32:0]         w_de;
    logic signed [49:0]  w_prod, w_prod_sh;
    logic [31:0]         w_x;
    logic [32:0]         w_neg;
    logic [22:0]         w_y;
    logic                w_accept;
    logic [15:0]         w_popcnt;
    logic [16:0]         w_acc_sum;
    logic                w_unused;

    assign w_e_lo = i_energy[32*32'(r_pair) +: 32];
    assign w_e_hi = i_energy[32*(32'(r_pair) + 32'd1) +: 32];
    assign w_de   = {w_e_hi[31], w_e_hi} - {w_e_lo[31], w_e_lo};

    assign w_prod    = $signed({{17{w_de[32]}}, w_de}) * $signed(50'(DBETA));
    assign w_prod_sh = w_prod >>> 3;
    assign w_x       = w_prod_sh[31:0];

    // Base-2 exponential unit: y = 0x7FFFFF * 2^x for x <= 0, saturating at x >= 0.
    assign w_neg = 33'd0 - {w_x[31], w_x};
    always_comb begin
        w_y = 23'h7FFFFF;
        if (w_x[31]) begin
            if (w_neg > 33'd22) w_y = '0;
            else                w_y = 23'h7FFFFF >> w_neg[4:0];
        end
    end

    assign w_accept = !w_de[32] || (w_y > i_r_exchange[22:0]);

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NREP; i++) w_popcnt = w_popcnt + 16'(r_acc[i]);
    end
    assign w_acc_sum = 17'(r_accept_cnt) + 17'(w_popcnt);

    assign w_unused = ^{i_r_exchange[31:23], w_prod_sh[49:32]};

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_sweep_len  <= 16'd1;
            r_n_round    <= '0;
            r_parity     <= 1'b0;
            r_pair       <= '0;
            r_acc        <= '0;
            r_command    <= '0;
            r_round_cnt  <= '0;
            r_accept_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_sweep_len  <= w_sweep_len_nxt;
            r_n_round    <= w_n_round_nxt;
            r_parity     <= w_parity_nxt;
            r_pair       <= w_pair_nxt;
            r_acc        <= w_acc_nxt;
            r_command    <= w_command_nxt;
            r_round_cnt  <= w_round_cnt_nxt;
            r_accept_cnt <= w_accept_cnt_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state and next register values
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_sweep_len_nxt  = r_sweep_len;
        w_n_round_nxt    = r_n_round;
        w_parity_nxt     = r_parity;
        w_pair_nxt       = r_pair;
        w_acc_nxt        = r_acc;
        w_command_nxt    = '0;
        w_round_cnt_nxt  = r_round_cnt;
        w_accept_cnt_nxt = r_accept_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_sweep_len_nxt  = (i_sweep_len == '0) ? 16'd1 : i_sweep_len;
                    w_n_round_nxt    = i_n_round;
                    w_round_cnt_nxt  = '0;
                    w_accept_cnt_nxt = '0;
                    w_parity_nxt     = 1'b0;
                    w_acc_nxt        = '0;
                    w_pair_nxt       = '0;
                    w_timer_nxt      = w_sweep_len_nxt - 16'd1;
                    w_state_nxt      = (i_n_round == '0) ? S_DONE : S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (r_timer == '0) begin
                    w_timer_nxt = 16'(PIPE_LAT - 1);
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_DRAIN: begin
                if (r_timer == '0) begin
                    // With parity 1 and only two replicas there is no pair at all.
                    if (32'(r_parity) + 32'd1 < NREP_U) begin
                        w_pair_nxt  = PW'(r_parity);
                        w_state_nxt = S_EXCH;
                    end else begin
                        w_state_nxt = S_APPLY;
                    end
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_EXCH: begin
                w_acc_nxt[r_pair] = w_accept;
                if (32'(r_pair) + 32'd3 < NREP_U) w_pair_nxt  = r_pair + PW'(2);
                else                               w_state_nxt = S_APPLY;
            end
            S_APPLY: begin
                w_accept_cnt_nxt = w_acc_sum[16] ? 16'hFFFF : w_acc_sum[15:0];
                w_round_cnt_nxt  = r_round_cnt + 16'd1;
                w_parity_nxt     = !r_parity;
                w_acc_nxt        = '0;
                if (w_round_cnt_nxt == r_n_round) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_timer_nxt = r_sweep_len - 16'd1;
                    w_state_nxt = S_SWEEP;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Commands are computed from the final acceptance vector so they are
        // registered and appear exactly during the APPLY cycle.
        if (w_state_nxt == S_APPLY) begin
            for (int i = 0; i < NREP - 1; i++) begin
                if (w_acc_nxt[i]) begin
                    w_command_nxt[2*i +: 2]     = CMD_FOLW;
                    w_command_nxt[2*(i+1) +: 2] = CMD_PREV;
                end
            end
        end
    end

    assign o_metropolis_run = (r_state == S_SWEEP);
    assign o_command        = r_command;
    assign o_busy           = (r_state != S_IDLE);
    assign o_done           = (r_state == S_DONE);
    assign o_round_cnt      = r_round_cnt;
    assign o_accept_cnt     = r_accept_cnt;

endmodule

// File: tb/tb_exchange_scheduler.sv
// Bench for exchange_scheduler: directed table of runs (NREP=4 and NREP=2
// instances), an asynchronous reset abort, and randomized runs, all checked
// cycle by cycle against a phase-level reference model.

module tb_exchange_scheduler;

    localparam int PIPE  = 4;
    localparam int DBETA = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start4, start2;
    logic [15:0]   sweep_len, n_round;
    logic [127:0]  energy4;
    logic [63:0]   energy2;
    logic [31:0]   rx_word;

    logic          run4, busy4, done4, run2, busy2, done2;
    logic [7:0]    cmd4;
    logic [3:0]    cmd2;
    logic [15:0]   rcnt4, acnt4, rcnt2, acnt2;

    always #5 clk = ~clk;

    exchange_scheduler #(.NREP(4), .PIPE_LAT(PIPE), .DBETA(DBETA)) u_dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start4),
        .i_sweep_len(sweep_len), .i_n_round(n_round),
        .i_energy(energy4), .i_r_exchange(rx_word),
        .o_metropolis_run(run4), .o_command(cmd4), .o_busy(busy4),
        .o_done(done4), .o_round_cnt(rcnt4), .o_accept_cnt(acnt4)
    );

    exchange_scheduler #(.NREP(2), .PIPE_LAT(PIPE), .DBETA(DBETA)) u_dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start2),
        .i_sweep_len(sweep_len), .i_n_round(n_round),
        .i_energy(energy2), .i_r_exchange(rx_word),
        .o_metropolis_run(run2), .o_command(cmd2), .o_busy(busy2),
        .o_done(done2), .o_round_cnt(rcnt2), .o_accept_cnt(acnt2)
    );

    bit          sel2;
    logic        mon_run, mon_busy, mon_done;
    logic [7:0]  mon_cmd;
    logic [15:0] mon_rcnt, mon_acnt;
    assign mon_run  = sel2 ? run2  : run4;
    assign mon_busy = sel2 ? busy2 : busy4;
    assign mon_done = sel2 ? done2 : done4;
    assign mon_cmd  = sel2 ? {4'b0, cmd2} : cmd4;
    assign mon_rcnt = sel2 ? rcnt2 : rcnt4;
    assign mon_acnt = sel2 ? acnt2 : acnt4;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned rxa [0:511];        // random word driven in cycle c after start
    logic [10:0] exp_q [$];          // {run, busy, done, cmd[7:0]} per cycle
    int          exp_acc, exp_round;

    function automatic bit model_accept(input int de, input int unsigned r);
        longint x, y;
        if (de >= 0) return 1'b1;
        x = -((longint'(-de) * DBETA + 7) / 8);      // floor(de*dbeta/8)
        if (x < -30) y = 0;
        else         y = (longint'(1) << 23) - 1;
        if (x >= -30) y = y / (longint'(1) << (-x));
        return y > longint'(r & 32'h7FFFFF);
    endfunction

    task automatic build_model(input int nrep, input int s, input int n, input int e[4]);
        int          sp, parity, acc, cnt;
        logic [7:0]  cmd;
        sp = (s == 0) ? 1 : s;
        exp_q.delete();
        parity = 0;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            repeat (sp)   exp_q.push_back({3'b110, 8'h00});
            repeat (PIPE) exp_q.push_back({3'b010, 8'h00});
            cmd = '0;
            cnt = 0;
            for (int p = parity; p + 1 < nrep; p += 2) begin
                if (model_accept(e[p+1] - e[p], rxa[exp_q.size() + 1])) begin
                    cmd[2*p +: 2]     = 2'd2;
                    cmd[2*(p+1) +: 2] = 2'd1;
                    cnt++;
                end
                exp_q.push_back({3'b010, 8'h00});
            end
            exp_q.push_back({3'b010, cmd});
            acc = (acc + cnt > 65535) ? 65535 : acc + cnt;
            parity = 1 - parity;
        end
        exp_q.push_back({3'b011, 8'h00});
        exp_q.push_back({3'b000, 8'h00});
        exp_acc   = acc;
        exp_round = n;
    endtask

    task automatic run_case(input string tag, input int nrep, input int s, input int n,
                            input int e[4], input bit hold,
                            output int done_cyc, output int run_cnt);
        int sp;
        sp = (s == 0) ? 1 : s;
        sel2 = (nrep == 2);
        for (int i = 0; i < 4; i++) energy4[32*i +: 32] = 32'(e[i]);
        for (int i = 0; i < 2; i++) energy2[32*i +: 32] = 32'(e[i]);
        sweep_len = 16'(s);
        n_round   = 16'(n);
        build_model(nrep, s, n, e);
        done_cyc = 0;
        run_cnt  = 0;
        @(negedge clk);
        if (sel2) start2 = 1'b1; else start4 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin start2 = 1'b0; start4 = 1'b0; end
        for (int c = 1; c <= exp_q.size(); c++) begin
            rx_word = rxa[c];
            if (c > sp) begin start2 = 1'b0; start4 = 1'b0; end
            @(negedge clk);
            check($sformatf("%s cyc%0d", tag, c), {mon_run, mon_busy, mon_done, mon_cmd}, exp_q[c-1]);
            if (mon_done && done_cyc == 0) done_cyc = c;
            if (mon_run) run_cnt++;
            @(posedge clk);
            #1;
        end
        check({tag, " round_cnt"},  mon_rcnt, 64'(exp_round));
        check({tag, " accept_cnt"}, mon_acnt, 64'(exp_acc));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          nrep;
        int          s;
        int          n;
        int          e0, e1, e2, e3;
        int unsigned r;
        bit          hold;
        int          x_acc;
        int          x_round;
        int          x_cycles;
        int          x_run;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int dc, rc;
        int e[4];

        tbl[0] = '{4, 3, 1, 40, 30, 20, 10, 32'h007FFFFF, 1'b0, 0, 1, 11, 3};
        tbl[1] = '{4, 3, 2, 10, 20, 30, 40, 32'h007FFFFF, 1'b1, 3, 2, 20, 6};
        tbl[2] = '{4, 5, 1, 40, 30, 20, 10, 32'h00000000, 1'b0, 2, 1, 13, 5};
        tbl[3] = '{4, 0, 0, 40, 30, 20, 10, 32'h00000000, 1'b0, 0, 0, 1, 0};
        tbl[4] = '{4, 0, 1, 40, 30, 20, 10, 32'hFF7FFFFF, 1'b0, 0, 1, 9, 1};
        tbl[5] = '{4, 2, 3, 0, 100, 50, 50, 32'h00000000, 1'b0, 5, 3, 27, 6};
        tbl[6] = '{4, 1, 1, 1000, 0, 0, 1000, 32'h00000000, 1'b0, 1, 1, 9, 1};
        tbl[7] = '{2, 1, 2, 10, 20, 0, 0, 32'h007FFFFF, 1'b0, 1, 2, 14, 2};

        rst_n = 1'b0; start4 = 1'b0; start2 = 1'b0; sel2 = 1'b0;
        sweep_len = '0; n_round = '0; energy4 = '0; energy2 = '0; rx_word = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset run",    run4,  64'd0);
        check("reset busy",   busy4, 64'd0);
        check("reset done",   done4, 64'd0);
        check("reset cmd",    cmd4,  64'd0);
        check("reset rcnt",   rcnt4, 64'd0);
        check("reset acnt",   acnt4, 64'd0);
        check("reset busy2",  busy2, 64'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < 512; c++) rxa[c] = tbl[t].r;
            e = '{tbl[t].e0, tbl[t].e1, tbl[t].e2, tbl[t].e3};
            run_case($sformatf("vec%0d", t), tbl[t].nrep, tbl[t].s, tbl[t].n, e, tbl[t].hold, dc, rc);
            check($sformatf("vec%0d accept_cnt", t), mon_acnt, 64'(tbl[t].x_acc));
            check($sformatf("vec%0d round_cnt", t),  mon_rcnt, 64'(tbl[t].x_round));
            check($sformatf("vec%0d done_cycle", t), 64'(dc),  64'(tbl[t].x_cycles));
            check($sformatf("vec%0d run_cycles", t), 64'(rc),  64'(tbl[t].x_run));
        end

        // Reset asserted during the round-1 exchange cycle aborts immediately.
        sel2 = 1'b0;
        energy4 = {32'd40, 32'd30, 32'd20, 32'd10};
        sweep_len = 16'd3;
        n_round = 16'd2;
        rx_word = 32'h007FFFFF;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (17) @(posedge clk);
        @(negedge clk);
        check("abort pre rcnt", rcnt4, 64'd1);
        check("abort pre acnt", acnt4, 64'd2);
        check("abort pre busy", busy4, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort run",  run4,  64'd0);
        check("abort busy", busy4, 64'd0);
        check("abort done", done4, 64'd0);
        check("abort cmd",  cmd4,  64'd0);
        check("abort rcnt", rcnt4, 64'd0);
        check("abort acnt", acnt4, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 512; c++) rxa[c] = 32'h007FFFFF;
        e = '{40, 30, 20, 10};
        run_case("post_abort", 4, 3, 1, e, 1'b0, dc, rc);
        check("post_abort done_cycle", 64'(dc), 64'd11);

        // Randomized runs against the model.
        for (int t = 0; t < 24; t++) begin
            int nrep, s, n;
            nrep = ($urandom % 3 == 0) ? 2 : 4;
            s = $urandom_range(0, 6);
            n = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) e[i] = int'($urandom_range(0, 80)) - 40;
            for (int c = 0; c < 512; c++) rxa[c] = $urandom >> $urandom_range(0, 22);
            run_case($sformatf("rnd%0d", t), nrep, s, n, e, 1'b0, dc, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
